// File: rtl/fp_add_writeback.sv
// fp_add_writeback: in-order writeback/trap stage behind the FP adder, owning fcsr flags/cause/enables.
// Optional FP_WB_FLUSH_EN adds a flush input that empties the buffer and drops a pending trap.
module fp_add_writeback #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_result,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_underflow,
    input  logic                  in_overflow,
    input  logic                  in_inexact,
    input  logic                  wb_stall,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [31:0]           wb_data,
    input  logic                  csr_we,
    input  logic [5:0]            csr_wdata,
    output logic [2:0]            fcsr_flags,
    output logic [2:0]            fcsr_cause,
    output logic [2:0]            fcsr_enables,
`ifdef FP_WB_FLUSH_EN
    input  logic                  flush,
`endif
    output logic                  trap,
    output logic                  trap_pending,
    input  logic                  trap_ack
);
    localparam int AW = $clog2(DEPTH);
`ifndef FP_WB_FLUSH_EN
    localparam logic flush = 1'b0;
`endif
    logic [31:0]           res_q  [DEPTH];
    logic [REG_ADDR_W-1:0] dest_q [DEPTH];
    logic [2:0]            cause_q[DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [AW:0]           count;
    logic [2:0]            c;
    logic                  push, pop, hit, commit;
    // rst_n gating keeps in_ready low while the stage is held in reset
    assign in_ready = rst_n & (count < (AW+1)'(DEPTH)) & ~trap_pending;
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = (count != '0) & ~wb_stall & ~trap_pending & ~flush;
    assign c        = cause_q[rd_ptr];
    assign hit      = |(c & fcsr_enables);
    assign commit   = pop & ~hit;
    always_ff @(posedge clk) begin
        if (push) begin
            res_q[wr_ptr]   <= in_result;
            dest_q[wr_ptr]  <= in_dest;
            cause_q[wr_ptr] <= {in_overflow, in_underflow, in_inexact};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            wb_en        <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            fcsr_flags   <= '0;
            fcsr_cause   <= '0;
            fcsr_enables <= '0;
            trap         <= 1'b0;
            trap_pending <= 1'b0;
        end else begin
            wb_en <= commit;
            trap  <= pop & hit;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
                wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
                count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
            if (commit) begin
                wb_addr <= dest_q[rd_ptr];
                wb_data <= res_q[rd_ptr];
            end
            if (pop)
                fcsr_cause <= c;
            // a trapped entry reports its cause but never accrues into the sticky flags
            if (csr_we)
                fcsr_flags <= csr_wdata[2:0] | (commit ? c : 3'b000);
            else if (commit)
                fcsr_flags <= fcsr_flags | c;
            if (csr_we)
                fcsr_enables <= csr_wdata[5:3];
            if (flush)
                trap_pending <= 1'b0;
            else if (pop & hit)
                trap_pending <= 1'b1;
            else if (trap_ack)
                trap_pending <= 1'b0;
        end
    end
endmodule

// File: doc/fp_add_writeback.md
Name: fp_add_writeback

Overview:
- Pipeline stage directly downstream of the FP adder/subtractor.
- Accepts its 32-bit result plus underflow/overflow/inexact flags via valid/ready into a 2-entry skid buffer.
- Retires entries in order: either writes the result to the FP register file, or raises a precise trap when an enabled exception occurs.
- Owns the sticky flag, cause and enable fields of the FP status register.

Parameters:
- REG_ADDR_W, 5, width of FP register destination address.
- DEPTH, 2, buffer entries; must be a power of two, 2 or greater.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_result  in  32  adder result.
- in_dest  in  REG_ADDR_W  destination FP register.
- in_underflow  in  1  adder underflow flag.
- in_overflow  in  1  adder overflow flag.
- in_inexact  in  1  adder inexact flag.
- wb_stall  in  1  register file busy; hold the head entry.
- wb_en  out  1  register write strobe, one cycle.
- wb_addr  out  REG_ADDR_W  write address.
- wb_data  out  32  write data.
- csr_we  in  1  status register write.
- csr_wdata  in  6  {enables[2:0], flags[2:0]}.
- fcsr_flags  out  3  sticky flags.
- fcsr_cause  out  3  cause of last retired entry.
- fcsr_enables  out  3  trap enables.
- trap  out  1  one-cycle trap pulse.
- trap_pending  out  1  trap raised, not yet acknowledged.
- trap_ack  in  1  clears trap_pending.

Behaviour:
- Flag bit order everywhere: bit0 inexact, bit1 underflow, bit2 overflow.
- Reset (rst_n low, async):
  - Buffer empty.
  - All outputs 0: wb_en, wb_addr, wb_data, fcsr_flags, fcsr_cause, fcsr_enables, trap, trap_pending.
  - in_ready is 0 while in reset and 1 on the first cycle after release.
  - Reset mid-operation discards all buffered entries and any pending trap.
- Push: in_valid & in_ready pushes {result, dest, flags} at the tail.
- in_ready = (count < DEPTH) & ~trap_pending. It is registered-free combinational on count/trap_pending only, never on in_valid.
- Pop happens when count > 0 & ~wb_stall & ~trap_pending. The head cause c is popped, and on the next edge:
  - If (c & fcsr_enables) != 0: trap=1 for one cycle, trap_pending=1, fcsr_cause=c, wb_en=0. fcsr_flags is NOT updated; the result is discarded.
  - Else: wb_en=1, wb_addr/wb_data = head entry, fcsr_cause=c, fcsr_flags |= c.
- wb_en and trap are single-cycle pulses, 0 when no pop occurs. wb_addr/wb_data hold their last value.
- Latency: an entry pushed at edge N into an empty buffer with no stall gives wb_en high after edge N+1.
- Throughput: one entry per cycle sustained.
- Simultaneous push and pop when full is not allowed, because in_ready uses the pre-pop count.
- Simultaneous push and pop when neither full nor empty: count unchanged.
- Pointers wrap modulo DEPTH.
- trap_pending: cleared by trap_ack on the next edge. Entries behind the trapped one stay buffered and resume afterwards. trap_ack with no trap pending is ignored.
- CSR write on the same edge as a non-trapping pop:
  - fcsr_flags = csr_wdata[2:0] | c.
  - fcsr_enables = csr_wdata[5:3].
  - New enables apply from the following pop.
- CSR write alone: fields loaded directly.
- fcsr_cause is not writable.
- wb_stall held: the head entry is held indefinitely, and the buffer fills then deasserts in_ready.

Optional Feature:
- FP_WB_FLUSH_EN
  - Defined: adds input port flush (1 bit). On an edge with flush=1:
    - Buffer emptied.
    - trap_pending cleared.
    - Same-edge push and pop suppressed (no wb_en, no trap, no flag update).
    - CSR write on that edge still applies.
  - Undefined: no flush port; buffer cleared only by reset.

Test Plan:
- Reset, then push result 0x3FC00000 dest 3 with flags 000 -> wb_en=1, wb_addr=3, wb_data=0x3FC00000 one cycle after accept; fcsr_flags=000.
- Push inexact=1 with enables=000 -> written back; fcsr_cause=001, fcsr_flags=001. Then push flags 000 -> fcsr_cause=000, fcsr_flags stays 001.
- Write csr_wdata=6'b100_000, push overflow=1 result 0x7F800000 -> trap pulse, trap_pending=1, no wb_en, in_ready=0. trap_ack -> trap_pending=0, in_ready=1.
- Hold wb_stall=1, push 3 entries back-to-back -> in_ready drops after 2 accepted. Release -> two writes on consecutive cycles, in order.
- Non-trapping pop with cause 010 on the same edge as csr_we with csr_wdata=6'b000_100 -> fcsr_flags=110.
- Assert rst_n low with 2 entries buffered and trap_pending=1 -> all outputs 0, no write after release.
